// File: rtl/kbd_ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// scan code set 2 prefix bytes and the letter make-code / ASCII tables.
package kbd_ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_CHECK
    } rx_state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;

    // E, D, B, F and R are the command letters kbd_music_ctrl acts on
    localparam logic [7:0] ASCII_A = 8'h41, ASCII_B = 8'h42, ASCII_C = 8'h43, ASCII_D = 8'h44;
    localparam logic [7:0] ASCII_E = 8'h45, ASCII_F = 8'h46, ASCII_G = 8'h47, ASCII_H = 8'h48;
    localparam logic [7:0] ASCII_I = 8'h49, ASCII_J = 8'h4A, ASCII_K = 8'h4B, ASCII_L = 8'h4C;
    localparam logic [7:0] ASCII_M = 8'h4D, ASCII_N = 8'h4E, ASCII_O = 8'h4F, ASCII_P = 8'h50;
    localparam logic [7:0] ASCII_Q = 8'h51, ASCII_R = 8'h52, ASCII_S = 8'h53, ASCII_T = 8'h54;
    localparam logic [7:0] ASCII_U = 8'h55, ASCII_V = 8'h56, ASCII_W = 8'h57, ASCII_X = 8'h58;
    localparam logic [7:0] ASCII_Y = 8'h59, ASCII_Z = 8'h5A;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes and deglitches the connector lines and
// assembles 11-bit frames, flagging parity/start/stop errors and stalls.
module ps2_frame_rx
    import kbd_ps2_pkg::*;
#(
    parameter int CLK_FILTER_LEN = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int FILT_W = $clog2(CLK_FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]        clk_sync;
    logic [1:0]        data_sync;
    logic              ps2_bit;
    logic              clk_filt;
    logic [FILT_W-1:0] filt_cnt;
    logic              fall_stb;
    rx_state_e         state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              parity_bit;
    logic              stop_ok;
    logic [TO_W-1:0]   idle_cnt;
    logic              frame_ok;

    always_ff @(posedge clk) begin
        clk_sync  <= {clk_sync[0], ps2_clk};
        data_sync <= {data_sync[0], ps2_data};
    end

    assign ps2_bit = data_sync[1];

    // Filtered clock idles high like the bus; a level flip needs a run of equal samples
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall_stb <= 1'b0;
        end else begin
            fall_stb <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(CLK_FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                fall_stb <= ~clk_sync[1];
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign frame_ok   = stop_ok & (^{shift, parity_bit});
    assign byte_valid = (state == ST_CHECK) && frame_ok;
    assign rx_byte    = shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            idle_cnt    <= '0;
            stop_ok     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (fall_stb) begin
                        if (!ps2_bit) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                end
                ST_DATA, ST_PARITY, ST_STOP: begin
                    if (fall_stb) begin
                        idle_cnt <= '0;
                        case (state)
                            ST_DATA: begin
                                shift   <= {ps2_bit, shift[7:1]};
                                bit_cnt <= bit_cnt + 1'b1;
                                if (bit_cnt == 3'd7) state <= ST_PARITY;
                            end
                            ST_PARITY: begin
                                parity_bit <= ps2_bit;
                                state      <= ST_STOP;
                            end
                            default: begin
                                stop_ok <= ps2_bit;
                                state   <= ST_CHECK;
                            end
                        endcase
                    end else if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state       <= ST_IDLE;
                        frame_error <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state <= ST_IDLE;
                    if (!frame_ok) frame_error <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_ascii_rx.sv
// PS/2 keyboard to ASCII front end: filters break/extended sequences, maps
// letter make codes to uppercase ASCII and stretches the update strobe.
module ps2_kbd_ascii_rx
    import kbd_ps2_pkg::*;
#(
    parameter int CLK_FILTER_LEN      = 4,
    parameter int TIMEOUT_CYCLES      = 50000,
    parameter int UPDATE_PULSE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] kbd_received_ascii_code,
    output logic       update_code,
    output logic       frame_error
);

    localparam int PW = $clog2(UPDATE_PULSE_CYCLES + 1);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_error;
    logic          break_pending;
    logic          ext_pending;
    logic [PW-1:0] pulse_cnt;
    logic [8:0]    map_res;
    logic          decode_hit;

    ps2_frame_rx #(
        .CLK_FILTER_LEN(CLK_FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .frame_error(rx_error)
    );

    assign frame_error = rx_error;

    // Returns {hit, ascii}; hit is clear for anything that is not a letter make code
    function automatic logic [8:0] map_scan(input logic [7:0] sc);
        case (sc)
            SC_A: return {1'b1, ASCII_A};  SC_B: return {1'b1, ASCII_B};
            SC_C: return {1'b1, ASCII_C};  SC_D: return {1'b1, ASCII_D};
            SC_E: return {1'b1, ASCII_E};  SC_F: return {1'b1, ASCII_F};
            SC_G: return {1'b1, ASCII_G};  SC_H: return {1'b1, ASCII_H};
            SC_I: return {1'b1, ASCII_I};  SC_J: return {1'b1, ASCII_J};
            SC_K: return {1'b1, ASCII_K};  SC_L: return {1'b1, ASCII_L};
            SC_M: return {1'b1, ASCII_M};  SC_N: return {1'b1, ASCII_N};
            SC_O: return {1'b1, ASCII_O};  SC_P: return {1'b1, ASCII_P};
            SC_Q: return {1'b1, ASCII_Q};  SC_R: return {1'b1, ASCII_R};
            SC_S: return {1'b1, ASCII_S};  SC_T: return {1'b1, ASCII_T};
            SC_U: return {1'b1, ASCII_U};  SC_V: return {1'b1, ASCII_V};
            SC_W: return {1'b1, ASCII_W};  SC_X: return {1'b1, ASCII_X};
            SC_Y: return {1'b1, ASCII_Y};  SC_Z: return {1'b1, ASCII_Z};
            default: return 9'd0;
        endcase
    endfunction

    assign map_res    = map_scan(rx_byte);
    assign decode_hit = rx_valid && (rx_byte != SC_BREAK) && (rx_byte != SC_EXT)
                        && !break_pending && !ext_pending && map_res[8];

    always_ff @(posedge clk) begin
        if (reset) begin
            break_pending           <= 1'b0;
            ext_pending             <= 1'b0;
            kbd_received_ascii_code <= 8'h00;
            pulse_cnt               <= '0;
            update_code             <= 1'b0;
        end else begin
            if (rx_valid) begin
                if (rx_byte == SC_BREAK) begin
                    break_pending <= 1'b1;
                end else if (rx_byte == SC_EXT) begin
                    ext_pending <= 1'b1;
                end else if (break_pending || ext_pending) begin
                    break_pending <= 1'b0;
                    ext_pending   <= 1'b0;
                end
            end
            // A retrigger reloads the counter so the strobe never drops between keys
            if (decode_hit) begin
                kbd_received_ascii_code <= map_res[7:0];
                pulse_cnt               <= PW'(UPDATE_PULSE_CYCLES);
                update_code             <= 1'b1;
            end else begin
                if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - 1'b1;
                update_code <= (pulse_cnt > PW'(1));
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ascii_rx.sv
// Directed bench for ps2_kbd_ascii_rx: drives PS/2 frames bit by bit and
// checks decoded codes, strobe length and error pulses.
module tb_ps2_kbd_ascii_rx;

    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       update_code;
    logic       frame_error;

    int checks   = 0;
    int failures = 0;
    int hi_total = 0, rise_total = 0, fe_total = 0, fe_wide = 0;
    int s_hi, s_rise, s_fe, s_wide;
    logic upd_prev = 1'b0, fe_prev = 1'b0;
    logic [10:0] f;

    always #5 clk = ~clk;

    ps2_kbd_ascii_rx dut (
        .clk                    (clk),
        .reset                  (reset),
        .ps2_clk                (ps2_clk),
        .ps2_data               (ps2_data),
        .kbd_received_ascii_code(code),
        .update_code            (update_code),
        .frame_error            (frame_error)
    );

    always @(negedge clk) begin
        if (update_code === 1'b1) hi_total++;
        if (update_code === 1'b1 && upd_prev !== 1'b1) rise_total++;
        if (frame_error === 1'b1) begin
            fe_total++;
            if (fe_prev === 1'b1) fe_wide++;
        end
        upd_prev = update_code;
        fe_prev  = frame_error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_hi   = hi_total;
        s_rise = rise_total;
        s_fe   = fe_total;
        s_wide = fe_wide;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic par;
        par = (~^b) ^ bad_par;
        send_bits({1'b1, par, b, 1'b0}, 11);
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        check("reset_code", code, 8'h00);
        check("reset_update", update_code, 1'b0);
        check("reset_frame_error", frame_error, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // 1: make code E
        snap();
        send_frame(8'h24, 1'b0);
        check("t1_code", code, 8'h45);
        check("t1_pulse_len", hi_total - s_hi, 16);
        check("t1_pulse_count", rise_total - s_rise, 1);
        check("t1_no_error", fe_total - s_fe, 0);

        // 2: release of R suppressed, next R make decodes
        snap();
        send_frame(8'hF0, 1'b0);
        send_frame(8'h2D, 1'b0);
        check("t2_break_no_update", rise_total - s_rise, 0);
        check("t2_break_code_held", code, 8'h45);
        snap();
        send_frame(8'h2D, 1'b0);
        check("t2_code", code, 8'h52);
        check("t2_pulse_len", hi_total - s_hi, 16);
        check("t2_pulse_count", rise_total - s_rise, 1);

        // 3: bad parity after a valid E
        send_frame(8'h24, 1'b0);
        snap();
        send_frame(8'h32, 1'b1);
        check("t3_error_pulses", fe_total - s_fe, 1);
        check("t3_error_width", fe_wide - s_wide, 0);
        check("t3_no_update", rise_total - s_rise, 0);
        check("t3_code_held", code, 8'h45);

        // 4: stalled frame times out, next frame decodes
        snap();
        f = {1'b1, 1'b0, 8'h23, 1'b0};
        send_bits(f, 6);
        repeat (50100) @(negedge clk);
        check("t4_timeout_error", fe_total - s_fe, 1);
        check("t4_timeout_width", fe_wide - s_wide, 0);
        check("t4_no_update", rise_total - s_rise, 0);
        snap();
        send_frame(8'h23, 1'b0);
        check("t4_code", code, 8'h44);
        check("t4_pulse_count", rise_total - s_rise, 1);
        check("t4_no_error", fe_total - s_fe, 0);

        // 5: reset during bit 4 of a frame
        f = {1'b1, 1'b1, 8'h2B, 1'b0};
        send_bits(f, 5);
        @(negedge clk) ps2_data = f[5];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_reset_code", code, 8'h00);
        check("t5_reset_update", update_code, 1'b0);
        check("t5_reset_error", frame_error, 1'b0);
        reset = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        snap();
        send_frame(8'h2B, 1'b0);
        check("t5_code", code, 8'h46);
        check("t5_pulse_len", hi_total - s_hi, 16);
        check("t5_no_error", fe_total - s_fe, 0);

        // 6: unmapped Esc, extended F, then back-to-back A decodes
        snap();
        send_frame(8'h76, 1'b0);
        check("t6_esc_no_update", rise_total - s_rise, 0);
        check("t6_esc_code_held", code, 8'h46);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h2B, 1'b0);
        check("t6_ext_no_update", rise_total - s_rise, 0);
        check("t6_ext_code_held", code, 8'h46);
        check("t6_no_error", fe_total - s_fe, 0);
        snap();
        @(negedge clk);
        force dut.rx_byte  = 8'h1C;
        force dut.rx_valid = 1'b1;
        @(negedge clk);
        force dut.rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        force dut.rx_valid = 1'b1;
        @(negedge clk);
        force dut.rx_valid = 1'b0;
        @(negedge clk);
        release dut.rx_valid;
        release dut.rx_byte;
        repeat (30) @(negedge clk);
        check("t6_retrig_code", code, 8'h41);
        check("t6_retrig_len", hi_total - s_hi, 21);
        check("t6_retrig_continuous", rise_total - s_rise, 1);
        snap();
        send_frame(8'h1C, 1'b0);
        check("t6_repeat_code", code, 8'h41);
        check("t6_repeat_pulse", rise_total - s_rise, 1);
        check("t6_repeat_len", hi_total - s_hi, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
